matrix_scan_arbiter: RTL and testbench

Shares the 8x8 RGB LED matrix between up to three frame sources: game playfield, LOSE overlay and WIN overlay. It performs per-row arbitration and row scanning, and inserts an anti-ghosting blanking interval at the start of each row. It drives the matrix pins R1/G2/B3/COMM directly, replacing per-module scan logic. Grant changes occur only at frame boundaries, so a frame never tears.

---
 rtl/matrix_scan_arbiter_if.sv | 25 ++
 rtl/matrix_scan_arbiter.sv | 170 +++++++++++++++++
 tb/tb_matrix_scan_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_scan_arbiter_if.sv
// Source/matrix bundle for the LED matrix arbiter: requests, grant, row address,
// per-source row data and the active-low matrix pin drives.
interface matrix_scan_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  gnt;
  logic [2:0]  row_addr;
  logic [23:0] src_r;
  logic [23:0] src_g;
  logic [23:0] src_b;
  logic [0:7]  R1;
  logic [0:7]  G2;
  logic [0:7]  B3;
  logic [3:0]  COMM;
  logic        frame_start;

  modport master (
    input  req, src_r, src_g, src_b,
    output gnt, row_addr, R1, G2, B3, COMM, frame_start
  );

  modport slave (
    output req, src_r, src_g, src_b,
    input  gnt, row_addr, R1, G2, B3, COMM, frame_start
  );
endinterface

// File: rtl/matrix_scan_arbiter.sv
// Fixed-priority frame arbiter and row scanner for an 8x8 RGB LED matrix.
// Grants change only at frame boundaries; each row slot opens with a blanking interval.
module matrix_scan_arbiter #(
  parameter int unsigned DWELL = 3125,
  parameter int unsigned BLANK = 16
) (
  input logic                  CLK,
  input logic                  restart,
  matrix_scan_arbiter_if.master bus
);

  localparam int unsigned CW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned RW  = 3;
  localparam int unsigned PW  = 8;
  localparam int unsigned NS  = 3;

  localparam logic [PW-1:0] PIX_OFF  = 8'hFF;
  localparam logic [CW-1:0] C_SAMPLE = CW'(BLANK);
  localparam logic [CW-1:0] C_LAST   = CW'(DWELL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(7);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q,   row_d;
  logic [CW-1:0] c_q,     c_d;
  logic [NS-1:0] gnt_q,   gnt_d;
  logic [PW-1:0] r_q,     r_d;
  logic [PW-1:0] g_q,     g_d;
  logic [PW-1:0] b_q,     b_d;
  logic [3:0]    comm_q,  comm_d;
  logic          fs_q,    fs_d;

  logic [PW-1:0] sel_r, sel_g, sel_b;
  logic [RW-1:0] row_nxt;
  logic          at_sample, at_last_c, at_last_row, any_req;

  // WIN > LOSE > game
  function automatic logic [NS-1:0] pick(input logic [NS-1:0] rq);
    logic [NS-1:0] g;
    g = '0;
    if (rq[2])      g = 3'b100;
    else if (rq[1]) g = 3'b010;
    else if (rq[0]) g = 3'b001;
    return g;
  endfunction

  // Granted source's slice of the current row; grant is one-hot so the order is immaterial
  always_comb begin
    sel_r = bus.src_r[7:0];
    sel_g = bus.src_g[7:0];
    sel_b = bus.src_b[7:0];
    if (gnt_q[1]) begin
      sel_r = bus.src_r[15:8];
      sel_g = bus.src_g[15:8];
      sel_b = bus.src_b[15:8];
    end
    if (gnt_q[2]) begin
      sel_r = bus.src_r[23:16];
      sel_g = bus.src_g[23:16];
      sel_b = bus.src_b[23:16];
    end
  end

  assign at_sample   = (c_q == C_SAMPLE);
  assign at_last_c   = (c_q == C_LAST);
  assign at_last_row = (row_q == ROW_LAST);
  assign any_req     = |bus.req;
  assign row_nxt     = row_q + RW'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    c_d     = c_q;
    gnt_d   = gnt_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    comm_d  = comm_q;
    fs_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        row_d  = '0;
        c_d    = '0;
        gnt_d  = '0;
        r_d    = PIX_OFF;
        g_d    = PIX_OFF;
        b_d    = PIX_OFF;
        comm_d = 4'b0000;
        if (any_req) begin
          state_d = SCAN;
          gnt_d   = pick(bus.req);
          comm_d  = {1'b1, RW'(0)};
          fs_d    = 1'b1;
        end
      end

      SCAN: begin
        c_d = c_q + CW'(1);
        if (at_sample) begin
          r_d = sel_r;
          g_d = sel_g;
          b_d = sel_b;
        end
        if (at_last_c) begin
          c_d    = '0;
          row_d  = row_nxt;
          r_d    = PIX_OFF;
          g_d    = PIX_OFF;
          b_d    = PIX_OFF;
          comm_d = {1'b1, row_nxt};
          // Frame boundary: the only point where the grant may change
          if (at_last_row) begin
            if (any_req) begin
              gnt_d = pick(bus.req);
              fs_d  = 1'b1;
            end else begin
              state_d = IDLE;
              gnt_d   = '0;
              row_d   = '0;
              comm_d  = 4'b0000;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (restart) begin
      state_q <= IDLE;
      row_q   <= '0;
      c_q     <= '0;
      gnt_q   <= '0;
      r_q     <= PIX_OFF;
      g_q     <= PIX_OFF;
      b_q     <= PIX_OFF;
      comm_q  <= 4'b0000;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      c_q     <= c_d;
      gnt_q   <= gnt_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      comm_q  <= comm_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.row_addr    = row_q;
  assign bus.R1          = r_q;
  assign bus.G2          = g_q;
  assign bus.B3          = b_q;
  assign bus.COMM        = comm_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_matrix_scan_arbiter.sv
// Directed bench for matrix_scan_arbiter with short row slots (DWELL=8, BLANK=2).
module tb_matrix_scan_arbiter;

  localparam int unsigned DWELL = 8;
  localparam int unsigned BLANK = 2;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [34:0] exp;
  } vec_t;

  logic CLK;
  logic restart;
  int   errors;
  int   checks;

  matrix_scan_arbiter_if bus ();

  matrix_scan_arbiter #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .CLK     (CLK),
    .restart (restart),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Per-source test patterns, indexed by source number and row
  function automatic logic [7:0] mdl_r(input int s, input int row);
    logic [7:0] lo, hi;
    lo = 8'h01;
    hi = 8'h80;
    case (s)
      0:       return ~(lo << row);
      2:       return ~(hi >> row);
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] mdl_g(input int s, input int row);
    logic [7:0] lo;
    lo = 8'h01;
    if (s == 0) return 8'hFF;
    return ~(lo << row);
  endfunction

  function automatic logic [7:0] mdl_b(input int s, input int row);
    logic [7:0] hi;
    hi = 8'h80;
    if (s == 0) return ~(hi >> row);
    return 8'hFF;
  endfunction

  always_comb begin
    bus.src_r = {mdl_r(2, int'(bus.row_addr)), mdl_r(1, int'(bus.row_addr)), mdl_r(0, int'(bus.row_addr))};
    bus.src_g = {mdl_g(2, int'(bus.row_addr)), mdl_g(1, int'(bus.row_addr)), mdl_g(0, int'(bus.row_addr))};
    bus.src_b = {mdl_b(2, int'(bus.row_addr)), mdl_b(1, int'(bus.row_addr)), mdl_b(0, int'(bus.row_addr))};
  end

  function automatic logic [34:0] pk(input logic [2:0] g, input logic [2:0] row, input logic [3:0] comm,
                                     input logic [7:0] r, input logic [7:0] gr, input logic [7:0] b,
                                     input logic fs);
    return {g, row, comm, r, gr, b, fs};
  endfunction

  // Expected outputs for a granted source at (row, c); g==0 means idle
  function automatic logic [34:0] exp_vec(input logic [2:0] g, input int row, input int c);
    int s;
    logic [7:0] r, gr, b;
    if (g == 3'b000) return pk(3'b000, 3'd0, 4'b0000, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    s  = g[2] ? 2 : (g[1] ? 1 : 0);
    r  = (c <= int'(BLANK)) ? 8'hFF : mdl_r(s, row);
    gr = (c <= int'(BLANK)) ? 8'hFF : mdl_g(s, row);
    b  = (c <= int'(BLANK)) ? 8'hFF : mdl_b(s, row);
    return pk(g, 3'(row), {1'b1, 3'(row)}, r, gr, b, (row == 0) && (c == 0));
  endfunction

  function automatic logic [34:0] actual();
    return {bus.gnt, bus.row_addr, bus.COMM, bus.R1, bus.G2, bus.B3, bus.frame_start};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt/row/comm/R/G/B/fs=%h required %h", name, act, exp);
    end
  endtask

  task automatic run_span(input logic [2:0] g, input int row, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      tick();
      chk($sformatf("scan g%b r%0d c%0d", g, row, c), actual(), exp_vec(g, row, c));
    end
  endtask

  task automatic run_rows(input logic [2:0] g, input int r0, input int r1);
    for (int r = r0; r <= r1; r++) run_span(g, r, 0, int'(DWELL) - 1);
  endtask

  task automatic idle_chk(input string name);
    tick();
    chk(name, actual(), exp_vec(3'b000, 0, 0));
  endtask

  vec_t vecs [14];

  initial begin
    errors      = 0;
    checks      = 0;
    restart     = 1'b1;
    bus.req     = 3'b000;

    vecs[0]  = '{1'b1, 3'b000, pk(3'b000, 3'd0, 4'h0, 8'hFF, 8'hFF, 8'hFF, 1'b0)};
    vecs[1]  = '{1'b1, 3'b000, pk(3'b000, 3'd0, 4'h0, 8'hFF, 8'hFF, 8'hFF, 1'b0)};
    vecs[2]  = '{1'b0, 3'b001, pk(3'b001, 3'd0, 4'h8, 8'hFF, 8'hFF, 8'hFF, 1'b1)};
    vecs[3]  = '{1'b0, 3'b001, pk(3'b001, 3'd0, 4'h8, 8'hFF, 8'hFF, 8'hFF, 1'b0)};
    vecs[4]  = '{1'b0, 3'b001, pk(3'b001, 3'd0, 4'h8, 8'hFF, 8'hFF, 8'hFF, 1'b0)};
    vecs[5]  = '{1'b0, 3'b001, pk(3'b001, 3'd0, 4'h8, 8'hFE, 8'hFF, 8'h7F, 1'b0)};
    vecs[6]  = '{1'b0, 3'b001, pk(3'b001, 3'd0, 4'h8, 8'hFE, 8'hFF, 8'h7F, 1'b0)};
    vecs[7]  = '{1'b0, 3'b001, pk(3'b001, 3'd0, 4'h8, 8'hFE, 8'hFF, 8'h7F, 1'b0)};
    vecs[8]  = '{1'b0, 3'b001, pk(3'b001, 3'd0, 4'h8, 8'hFE, 8'hFF, 8'h7F, 1'b0)};
    vecs[9]  = '{1'b0, 3'b001, pk(3'b001, 3'd0, 4'h8, 8'hFE, 8'hFF, 8'h7F, 1'b0)};
    vecs[10] = '{1'b0, 3'b001, pk(3'b001, 3'd1, 4'h9, 8'hFF, 8'hFF, 8'hFF, 1'b0)};
    vecs[11] = '{1'b0, 3'b001, pk(3'b001, 3'd1, 4'h9, 8'hFF, 8'hFF, 8'hFF, 1'b0)};
    vecs[12] = '{1'b0, 3'b001, pk(3'b001, 3'd1, 4'h9, 8'hFF, 8'hFF, 8'hFF, 1'b0)};
    vecs[13] = '{1'b0, 3'b001, pk(3'b001, 3'd1, 4'h9, 8'hFD, 8'hFF, 8'hBF, 1'b0)};

    // Reset, then first frame of src0 through row 1, c=3
    for (int i = 0; i < 14; i++) begin
      restart = vecs[i].rst;
      bus.req = vecs[i].req;
      tick();
      chk($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    // Higher-priority request mid-frame waits for the boundary
    run_span(3'b001, 1, 4, int'(DWELL) - 1);
    run_rows(3'b001, 2, 2);
    run_span(3'b001, 3, 0, 3);
    bus.req = 3'b101;
    run_span(3'b001, 3, 4, int'(DWELL) - 1);
    run_rows(3'b001, 4, 7);
    run_rows(3'b100, 0, 2);
    bus.req = 3'b001;
    run_rows(3'b100, 3, 7);

    // Granted source drops its request mid-frame, then the arbiter idles
    run_rows(3'b001, 0, 1);
    run_span(3'b001, 2, 0, 2);
    bus.req = 3'b000;
    run_span(3'b001, 2, 3, int'(DWELL) - 1);
    run_rows(3'b001, 3, 7);
    idle_chk("idle after drop 0");
    idle_chk("idle after drop 1");
    idle_chk("idle after drop 2");

    // Simultaneous requests, winner drops mid-frame
    bus.req = 3'b111;
    run_rows(3'b100, 0, 2);
    run_span(3'b100, 3, 0, 3);
    bus.req = 3'b011;
    run_span(3'b100, 3, 4, int'(DWELL) - 1);
    run_rows(3'b100, 4, 7);
    run_rows(3'b010, 0, 4);
    run_span(3'b010, 5, 0, 4);

    // Reset mid-row overrides an active request
    restart = 1'b1;
    idle_chk("restart mid-row 0");
    idle_chk("restart mid-row 1");
    restart = 1'b0;
    bus.req = 3'b000;
    idle_chk("idle after restart 0");
    idle_chk("idle after restart 1");
    bus.req = 3'b001;
    run_rows(3'b001, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
